// File: rtl/pic_core_pkg.sv
// ============================================================================
// pic_core_pkg: shared bus select codes, phase encoding and opcode fields.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pic_core_pkg;

   localparam logic [3:0] SEL_W      = 4'd0;
   localparam logic [3:0] SEL_ALU    = 4'd1;
   localparam logic [3:0] SEL_FILE   = 4'd2;
   localparam logic [3:0] SEL_STATUS = 4'd3;

   typedef enum logic [1:0] {
      Q1 = 2'd0,
      Q2 = 2'd1,
      Q3 = 2'd2,
      Q4 = 2'd3
   } phase_t;

   typedef enum logic [2:0] {
      CLS_SYS     = 3'd0,
      CLS_MOVWF   = 3'd1,
      CLS_FILE    = 3'd2,
      CLS_BITSET  = 3'd3,
      CLS_BITTEST = 3'd4,
      CLS_LIT     = 3'd5,
      CLS_RETLW   = 3'd6,
      CLS_JUMP    = 3'd7
   } instr_class_t;

   localparam logic [5:0] OP_DECFSZ = 6'b001011;
   localparam logic [5:0] OP_SWAPF  = 6'b001110;
   localparam logic [5:0] OP_INCFSZ = 6'b001111;
   localparam logic [3:0] OP_MOVLW  = 4'b1100;
   localparam logic [3:0] OP_RETLW  = 4'b1000;

   function automatic logic dest_bit(input logic [11:0] i);
      return i[5];
   endfunction

   function automatic logic [1:0] bitop_sub(input logic [11:0] i);
      return i[9:8];
   endfunction

endpackage

`default_nettype wire

// File: rtl/instr_class_decoder.sv
// ============================================================================
// instr_class_decoder: combinational 12-bit instruction class decode.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_class_decoder
   import pic_core_pkg::*;
(
   input  logic [11:0]  instr,
   output instr_class_t cls,
   output logic         dest_d,
   output logic         is_skip,
   output logic         is_branch,
   output logic         writes_status,
   output logic [3:0]   q2_select
);

   logic [5:0] w_op6;
   logic [3:0] w_op4;
   logic       w_unused;

   assign w_op6    = instr[11:6];
   assign w_op4    = instr[11:8];
   // Register address bits only matter to the datapath, not to sequencing.
   assign w_unused = ^instr[4:0];

   always_comb begin
      cls           = CLS_SYS;
      dest_d        = dest_bit(instr);
      is_skip       = 1'b0;
      is_branch     = 1'b0;
      writes_status = 1'b0;
      q2_select     = SEL_STATUS;

      if (w_op6 == 6'd0) begin
         if (dest_bit(instr)) begin
            cls       = CLS_MOVWF;
            q2_select = SEL_W;
         end
      end else if (instr[11:10] == 2'b00) begin
         cls           = CLS_FILE;
         q2_select     = SEL_FILE;
         is_skip       = (w_op6 == OP_DECFSZ) || (w_op6 == OP_INCFSZ);
         writes_status = !((w_op6 == OP_DECFSZ) || (w_op6 == OP_INCFSZ) ||
                           (w_op6 == OP_SWAPF));
      end else if (instr[11:10] == 2'b01) begin
         q2_select = SEL_FILE;
         if (bitop_sub(instr)[1]) begin
            cls     = CLS_BITTEST;
            is_skip = 1'b1;
         end else begin
            cls     = CLS_BITSET;
         end
      end else if (instr[11:10] == 2'b11) begin
         cls           = CLS_LIT;
         q2_select     = SEL_W;
         writes_status = (w_op4 != OP_MOVLW);
      end else begin
         is_branch = 1'b1;
         cls       = (w_op4 == OP_RETLW) ? CLS_RETLW : CLS_JUMP;
      end
   end

endmodule

`default_nettype wire

// File: rtl/instr_cycle_sequencer.sv
// ============================================================================
// instr_cycle_sequencer: Q1-Q4 instruction-cycle controller for the PIC16C57
// core. Optional SEQ_PERF_CNT_EN adds retired/flushed instruction counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_cycle_sequencer
   import pic_core_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] instr,
   input  logic        stall,
   input  logic        skip_req,
   output logic [1:0]  q_phase,
   output logic [3:0]  bus_select,
   output logic        w_we,
   output logic        file_we,
   output logic        status_we,
   output logic        fetch_req,
   output logic        flush
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [15:0] retired_cnt,
   output logic [15:0] flush_cnt
`endif
);

   phase_t       r_phase;
   phase_t       w_phase_nxt;
   logic [11:0]  r_ir;
   logic         r_flush;
   logic         r_pend_skip;
   logic         r_pend_branch;

   instr_class_t w_cls;
   logic         w_dest_d;
   logic         w_is_skip;
   logic         w_is_branch;
   logic         w_writes_status;
   logic [3:0]   w_q2_select;
   logic         w_q4_run;

   instr_class_decoder u_decoder (
      .instr         (r_ir),
      .cls           (w_cls),
      .dest_d        (w_dest_d),
      .is_skip       (w_is_skip),
      .is_branch     (w_is_branch),
      .writes_status (w_writes_status),
      .q2_select     (w_q2_select)
   );

   assign q_phase  = r_phase;
   assign flush    = r_flush;
   assign w_q4_run = (r_phase == Q4) && !stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase <= Q1;
      end else begin
         r_phase <= w_phase_nxt;
      end
   end

   // Enables are pure decode of registered state, so reset drops them at once.
   always_comb begin
      w_phase_nxt = r_phase;
      bus_select  = SEL_STATUS;
      w_we        = 1'b0;
      file_we     = 1'b0;
      status_we   = 1'b0;
      fetch_req   = 1'b0;

      if (!stall) begin
         w_phase_nxt = phase_t'(r_phase + 2'd1);
      end

      case (r_phase)
         Q1:      bus_select = SEL_STATUS;
         Q2:      bus_select = w_q2_select;
         default: bus_select = SEL_ALU;
      endcase

      if (w_q4_run) begin
         fetch_req = 1'b1;
         if (!r_flush) begin
            w_we      = ((w_cls == CLS_FILE) && !w_dest_d) ||
                        (w_cls == CLS_LIT) || (w_cls == CLS_RETLW);
            file_we   = ((w_cls == CLS_FILE) && w_dest_d) ||
                        (w_cls == CLS_MOVWF) || (w_cls == CLS_BITSET);
            status_we = w_writes_status;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ir          <= 12'h000;
         r_flush       <= 1'b0;
         r_pend_skip   <= 1'b0;
         r_pend_branch <= 1'b0;
      end else if (!stall) begin
         if (r_phase == Q1) begin
            r_ir          <= instr;
            r_flush       <= r_pend_skip | r_pend_branch;
            r_pend_skip   <= 1'b0;
            r_pend_branch <= 1'b0;
         end else if ((r_phase == Q4) && !r_flush) begin
            // A flushed cycle must not arm a skip or branch of its own.
            r_pend_skip   <= w_is_skip & skip_req;
            r_pend_branch <= w_is_branch;
         end
      end
   end

`ifdef SEQ_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_cnt <= 16'h0000;
         flush_cnt   <= 16'h0000;
      end else if (w_q4_run) begin
         if (r_flush) begin
            flush_cnt   <= flush_cnt + 16'h0001;
         end else begin
            retired_cnt <= retired_cnt + 16'h0001;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_cycle_sequencer.sv
// ============================================================================
// tb_instr_cycle_sequencer: scoreboard bench for instr_cycle_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_cycle_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] instr = 12'h000;
   logic        stall = 1'b0;
   logic        skip_req = 1'b0;
   logic [1:0]  q_phase;
   logic [3:0]  bus_select;
   logic        w_we;
   logic        file_we;
   logic        status_we;
   logic        fetch_req;
   logic        flush;
`ifdef SEQ_PERF_CNT_EN
   logic [15:0] retired_cnt;
   logic [15:0] flush_cnt;
`endif

   instr_cycle_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instr      (instr),
      .stall      (stall),
      .skip_req   (skip_req),
      .q_phase    (q_phase),
      .bus_select (bus_select),
      .w_we       (w_we),
      .file_we    (file_we),
      .status_we  (status_we),
      .fetch_req  (fetch_req),
      .flush      (flush)
`ifdef SEQ_PERF_CNT_EN
      ,
      .retired_cnt(retired_cnt),
      .flush_cnt  (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic w;
      logic f;
      logic s;
      logic fl;
   } q4_t;

   typedef struct packed {
      logic       w;
      logic       f;
      logic       s;
      logic       skp;
      logic       br;
      logic [3:0] q2;
   } eff_t;

   q4_t         sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          mon_en   = 1'b0;
   int          exp_phase = 0;
   bit          exp_stall = 1'b0;

   int          m_phase = 0;
   bit          m_pend  = 1'b0;
   bit          m_flush = 1'b0;
   logic [11:0] m_ir    = 12'h000;
   int          m_ret   = 0;
   int          m_fl    = 0;

   q4_t         mon_exp;
   eff_t        mon_eff;

   // Architectural effect of one instruction, from the opcode map.
   function automatic eff_t effects(input logic [11:0] i);
      eff_t       e;
      logic [5:0] op6;
      logic       d;
      e   = '0;
      op6 = i[11:6];
      d   = i[5];
      e.q2 = 4'd3;
      if (op6 == 6'd0) begin
         if (d) begin
            e.f  = 1'b1;
            e.q2 = 4'd0;
         end
      end else if (i[11:10] == 2'b00) begin
         e.q2  = 4'd2;
         e.w   = !d;
         e.f   = d;
         e.s   = !(op6 inside {6'b001110, 6'b001011, 6'b001111});
         e.skp = op6 inside {6'b001011, 6'b001111};
      end else if (i[11:10] == 2'b01) begin
         e.q2  = 4'd2;
         e.f   = !i[9];
         e.skp = i[9];
      end else if (i[11:10] == 2'b11) begin
         e.q2 = 4'd0;
         e.w  = 1'b1;
         e.s  = (i[9:8] != 2'b00);
      end else begin
         e.br = 1'b1;
         e.w  = (i[9:8] == 2'b00);
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one clock's inputs and advance the reference model for that clock.
   task automatic step(input logic [11:0] ins, input bit st, input bit sk);
      eff_t e;
      instr     = ins;
      stall     = st;
      skip_req  = sk;
      exp_phase = m_phase;
      exp_stall = st;
      if (!st) begin
         if (m_phase == 0) begin
            m_ir    = ins;
            m_flush = m_pend;
            m_pend  = 1'b0;
         end else if (m_phase == 3) begin
            e = effects(m_ir);
            sb.push_back('{w: e.w & !m_flush, f: e.f & !m_flush,
                           s: e.s & !m_flush, fl: m_flush});
            if (m_flush) m_fl++;
            else         m_ret++;
            if (!m_flush) m_pend = (e.skp & sk) | e.br;
         end
         m_phase = (m_phase + 1) % 4;
      end
   endtask

   task automatic run_instr(input logic [11:0] ins, input bit sk, input int nq3, input bit rnd);
      int ns;
      for (int p = 0; p < 4; p++) begin
         ns = (p == 2) ? nq3 : 0;
         if (rnd && ($urandom_range(0, 5) == 0)) ns = ns + $urandom_range(1, 2);
         for (int k = 0; k < ns; k++) begin
            step(12'($urandom), 1'b1, 1'($urandom));
            tick();
         end
         step((p == 0) ? ins : 12'($urandom), 1'b0, (p == 3) ? sk : 1'($urandom));
         tick();
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_phase"}, 16'(q_phase), 16'd0);
      check({tag, "_sel"}, 16'(bus_select), 16'd3);
      check({tag, "_enables"}, 16'({w_we, file_we, status_we, fetch_req}), 16'd0);
      check({tag, "_flush"}, 16'(flush), 16'd0);
   endtask

   // Monitor: pops an expectation whenever the DUT requests a fetch.
   always @(negedge clk) begin
      if (mon_en) begin
         check("q_phase", 16'(q_phase), 16'(exp_phase));
         check("fetch_req", 16'(fetch_req), 16'((exp_phase == 3) && !exp_stall));
         if (fetch_req === 1'b1) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL scoreboard: fetch_req with no expected entry at %0t", $time);
            end else begin
               mon_exp = sb.pop_front();
               check("q4_w_f_s", 16'({w_we, file_we, status_we}),
                     16'({mon_exp.w, mon_exp.f, mon_exp.s}));
               check("q4_flush", 16'(flush), 16'(mon_exp.fl));
            end
         end else begin
            check("idle_enables", 16'({w_we, file_we, status_we}), 16'd0);
         end
         if (exp_phase == 0) begin
            check("sel_q1", 16'(bus_select), 16'd3);
         end else if (exp_phase == 1) begin
            mon_eff = effects(m_ir);
            check("sel_q2", 16'(bus_select), 16'(mon_eff.q2));
         end else if (exp_phase == 2) begin
            check("sel_q3", 16'(bus_select), 16'd1);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1 check_idle_outputs("reset");
      tick();
      tick();
      rst_n  = 1'b1;
      mon_en = 1'b1;

      run_instr(12'h1C5, 1'b0, 0, 1'b0);   // ADDWF 5,W
      run_instr(12'h025, 1'b0, 3, 1'b0);   // MOVWF 5, stalled in Q3
      run_instr(12'h6A5, 1'b1, 0, 1'b0);   // BTFSC taken
      run_instr(12'hC0F, 1'b0, 0, 1'b0);   // skipped MOVLW
      run_instr(12'hC0F, 1'b0, 0, 1'b0);
      run_instr(12'hA10, 1'b0, 0, 1'b0);   // GOTO
      run_instr(12'h1C5, 1'b0, 0, 1'b0);   // flushed by branch
      run_instr(12'h2F5, 1'b1, 0, 1'b0);   // DECFSZ taken
      run_instr(12'h6A5, 1'b1, 0, 1'b0);   // skipped skip: its skip is dropped
      run_instr(12'hC0F, 1'b0, 0, 1'b0);
      run_instr(12'h803, 1'b1, 0, 1'b0);   // RETLW, skip_req ignored
      run_instr(12'h025, 1'b1, 0, 1'b0);   // flushed

      for (int n = 0; n < 300; n++) begin
         run_instr(12'($urandom), 1'($urandom), 0, 1'b1);
      end

      // Asynchronous reset in the middle of Q3 after a branch.
      run_instr(12'hA10, 1'b0, 0, 1'b0);
      step(12'h1C5, 1'b0, 1'b0);
      tick();
      step(12'($urandom), 1'b0, 1'b0);
      tick();
      step(12'($urandom), 1'b0, 1'b0);
      #2;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check_idle_outputs("midreset");
      check("midreset_sb_empty", 16'(sb.size()), 16'd0);
      m_phase = 0;
      m_pend  = 1'b0;
      m_flush = 1'b0;
      m_ret   = 0;
      m_fl    = 0;
      tick();
      rst_n  = 1'b1;
      mon_en = 1'b1;
      run_instr(12'h1C5, 1'b0, 0, 1'b0);
      run_instr(12'h6A5, 1'b1, 0, 1'b0);
      run_instr(12'h1C5, 1'b0, 0, 1'b0);
      run_instr(12'h025, 1'b0, 0, 1'b0);

      check("final_sb_empty", 16'(sb.size()), 16'd0);
`ifdef SEQ_PERF_CNT_EN
      check("retired_cnt", retired_cnt, 16'(m_ret));
      check("flush_cnt", flush_cnt, 16'(m_fl));
`endif
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/instr_cycle_sequencer.md
Name: instr_cycle_sequencer

Overview:
- Four-phase (Q1–Q4) instruction-cycle controller for the PIC16C57 core; sits directly upstream of the data bus mux.
- Decodes the 12-bit instruction word and drives the mux select code each phase.
- Issues W, file and status write enables aligned to the bus mux's one-cycle registered output.
- Handles skip instructions, two-cycle branches and stall.

Parameters:
- SEL_W, 4'd0, bus select code for the W register.
- SEL_ALU, 4'd1, bus select code for the ALU result.
- SEL_FILE, 4'd2, bus select code for the register file.
- SEL_STATUS, 4'd3, bus select code for the status register.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- instr  input  12  instruction word; valid whenever fetch_req was asserted the previous cycle.
- stall  input  1  freezes phase and all state; outputs are forced inactive.
- skip_req  input  1  ALU zero/bit-test result; sampled in Q4.
- q_phase  output  2  current phase: 0=Q1, 1=Q2, 2=Q3, 3=Q4.
- bus_select  output  4  select code to the data bus mux.
- w_we  output  1  write W from the bus output.
- file_we  output  1  write addressed file register from the bus output.
- status_we  output  1  update status flags.
- fetch_req  output  1  request the next instruction word.
- flush  output  1  high for the whole cycle when the current cycle executes as a NOP.

Behaviour:
- Reset (async, rst_n=0):
  - q_phase=Q1, flush=0, latched instr=12'h000.
  - All enables 0; bus_select=SEL_STATUS.
  - Pending-skip and pending-branch flags cleared.
- Reset mid-cycle abandons the instruction; no write enable may glitch high.
- Phase sequence Q1→Q2→Q3→Q4→Q1, one clk each, when stall=0.
- stall=1: phase and latched instruction hold; w_we, file_we, status_we, fetch_req forced 0; bus_select holds.
- Q1: latch instr; latch flush = pending_skip OR pending_branch, then clear both; bus_select=SEL_STATUS.
- Q2: bus_select = SEL_FILE for file/bit ops; SEL_W for MOVWF and literal ops; SEL_STATUS otherwise.
- Q3: bus_select=SEL_ALU.
- Q4:
  - Write enables are asserted here; the bus mux registered the ALU value at the Q3→Q4 edge.
  - fetch_req=1.
  - If flush=1, all enables are 0.
- Decode classes, instr[11:0]:
  - NOP/system (000000000xxx): no writes.
  - MOVWF (0000001fffff): file_we.
  - CLRW/CLRF (000001dfffff): status_we; w_we if d=0, file_we if d=1.
  - File op (00, instr[9:6]≠0, d=instr[5]): w_we if d=0, file_we if d=1. status_we except SWAPF (001110), DECFSZ (001011), INCFSZ (001111).
  - Bit op (01bb): BCF/BSF give file_we. BTFSC/BTFSS give no write.
  - Literal (11xx): w_we; status_we except MOVLW (1100).
  - Branch (10xx): RETLW (1000) gives w_we. RETLW, CALL and GOTO set pending_branch.
- Skip: skip_req=1 in Q4 of DECFSZ, INCFSZ, BTFSC or BTFSS sets pending_skip. skip_req is ignored for all other classes.
- Simultaneous cases:
  - skip and branch cannot co-occur.
  - A flushed cycle never sets pending flags, so a skip over a skip instruction discards the second skip.
- stall in Q4 delays skip sampling to the first unstalled Q4.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined: adds outputs retired_cnt[15:0] and flush_cnt[15:0].
  - retired_cnt increments at each unstalled Q4 with flush=0.
  - flush_cnt increments at each unstalled Q4 with flush=1.
  - Both wrap at 16'hFFFF→0 and reset to 0.
- Undefined: no counters and no ports.

Decomposition:
- Shared package pic_core_pkg:
  - select codes (SEL_*);
  - phase encodings Q1–Q4;
  - opcode-class constants;
  - opcode field slices (d bit, bit-op subcode).
- One sub-module instr_class_decoder: combinational, instr → {class, dest_d, is_skip, is_branch, writes_status, q2_select}.

Test Plan:
- Reset then instr=12'h1C5 (ADDWF f=5, d=0), 4 cycles → selects {3,2,1,X}; in Q4 w_we=1, status_we=1, file_we=0, fetch_req=1.
- instr=12'h025 (MOVWF 5) → Q2 select=0; Q4 file_we=1, w_we=0, status_we=0.
- instr=12'h6A5 (BTFSC) with skip_req=1 in Q4, next instr=12'hC0F → next cycle flush=1, no enables; following MOVLW writes normally with w_we=1, status_we=0.
- instr=12'hA10 (GOTO) → following cycle flush=1; with SEQ_PERF_CNT_EN, flush_cnt +1 and retired_cnt +1.
- stall=1 held 3 cycles during Q3 → q_phase stays 2; enables 0; resumes to Q4 with correct writes.
- rst_n pulsed low mid-Q3 → immediately q_phase=0, all enables 0, pending flags cleared; no write occurs.
